borrow_lookahead_sub: RTL and testbench
=======================================

BORROW_LOOKAHEAD_SUB -- requirements
Module: borrow_lookahead_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are even and 2..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand set present.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow in.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
REQ-012 SHALL have port bout  output  1  borrow out; 1 iff a < b + bin (unsigned).

Function
REQ-013 SHALL define per-bit borrow generate g_i = ~a_i & b_i and propagate p_i = ~a_i | b_i.
REQ-014 SHALL combine bits in 2-bit lookahead groups: G = g1 | (p1 & g0), P = p1 & p0.
REQ-015 SHALL compute group borrows by lookahead across groups, with no ripple through individual bits inside a group.
REQ-016 SHALL make stage 1 register group G/P, the per-bit a^b and bin on acceptance (in_valid & in_ready).
REQ-017 SHALL make stage 2 register diff and bout from stage-1 contents.
REQ-018 SHALL assert out_valid exactly 2 cycles after acceptance when no stall occurs; throughput is 1 result per cycle with out_ready held high.
REQ-019 SHALL drive in_ready = ~s1_valid | ~s2_valid | out_ready; a combinational path out_ready->in_ready is allowed.
REQ-020 SHALL have no combinational path from in_valid, a, b or bin to any output.
REQ-021 SHALL hold diff, bout and out_valid stable while out_valid & ~out_ready.
REQ-022 SHALL advance both stages in the same cycle when out_valid & out_ready and a new acceptance occur together, without loss or duplication.
REQ-023 SHALL deliver results in acceptance order; ignore a, b and bin when in_valid & in_ready is 0.
REQ-024 SHALL treat bin=1 with a==b as bout=1 and diff all ones.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, clear s1_valid and s2_valid and set diff=0 and bout=0.
REQ-026 SHALL hold out_valid=0 and in_ready=0 while rst_n=0.
REQ-027 SHALL discard in-flight operands on reset mid-operation; the first output after reset comes from an operand accepted after release.
REQ-028 SHALL allow in_ready to go high in the first cycle after rst_n returns high.

Structure
REQ-029 SHALL place the group-width constant (2) and a struct {G, P} for group generate/propagate in shared package cla_pkg.
REQ-030 SHALL implement the 2-bit group cell as sub-module bla_group2 (inputs a[1:0], b[1:0]; outputs G, P, x[1:0]=a^b), instantiated WIDTH/2 times.
REQ-031 SHALL contain the pipeline control (valid/ready) only in the top module; no FSM beyond the two valid flags.

Verification
REQ-032 SHALL check, with WIDTH=16: a=0x0005, b=0x0003, bin=0, out_ready=1 -> 2 cycles later diff=0x0002, bout=0, out_valid=1 for 1 cycle.
REQ-033 SHALL check: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; a=0x8000, b=0x8000, bin=1 -> diff=0xFFFF, bout=1.
REQ-034 SHALL check: 8 back-to-back operands with out_ready=1 -> 8 consecutive out_valid cycles, correct in order, in_ready constantly 1.
REQ-035 SHALL check: out_ready=0 for 5 cycles while streaming -> in_ready drops after 2 held results, outputs stable, no loss once out_ready=1.
REQ-036 SHALL check: rst_n=0 for 1 cycle with both stages full -> out_valid=0, diff=0, bout=0 next cycle, and no stale result emitted later.
REQ-037 SHALL check: 10k random operands with random valid/ready -> every result matches a reference model of {bout,diff} = {1'b0,a} - b - bin.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the borrow-lookahead subtractor: group width and
// the group generate/propagate pair carried between the group cells and
// the lookahead network.
package cla_pkg;

    localparam int GROUP_W = 2;

    // Borrow generate/propagate of one lookahead group.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/bla_group2.sv
// Two-bit borrow-lookahead group cell. Per bit, a borrow is generated when
// the minuend bit is 0 and the subtrahend bit is 1, and an incoming borrow
// propagates unless the minuend bit is 1 and the subtrahend bit is 0.
module bla_group2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       g,
    output logic       p,
    output logic [1:0] x
);

    logic [1:0] bit_g;
    logic [1:0] bit_p;

    assign bit_g = ~a & b;
    assign bit_p = ~a | b;

    // Group terms: bit 1 generates, or bit 1 propagates a borrow made by bit 0.
    assign g = bit_g[1] | (bit_p[1] & bit_g[0]);
    assign p = bit_p[1] & bit_p[0];
    assign x = a ^ b;

endmodule

// File: rtl/borrow_lookahead_sub.sv
// Two-stage pipelined subtractor: diff = a - b - bin, bout = borrow out.
// Stage 1 captures per-group generate/propagate, a^b and bin; stage 2
// resolves all group borrows with a flat lookahead and registers the result.
//
// Handshake: a transfer happens on a port in any cycle where its valid and
// ready are both 1 at the rising edge. The producer holds its data while
// valid & ~ready; out_valid/diff/bout are held stable while out_valid &
// ~out_ready. in_ready may depend combinationally on out_ready, but no
// output depends combinationally on in_valid, a, b or bin.
module borrow_lookahead_sub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16  // even, 2..64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int NG = WIDTH / GROUP_W;

    // Combinational group cells on the raw operands.
    gp_t  [NG-1:0]    grp_c;
    logic [WIDTH-1:0] x_c;
    // Bit-0 generate/propagate of each group: needed to form the borrow into
    // bit 1, which the group-level G/P alone cannot recover.
    logic [NG-1:0]    g0_c;
    logic [NG-1:0]    p0_c;

    // Stage 1 contents.
    logic             s1_valid;
    gp_t  [NG-1:0]    s1_gp;
    logic [WIDTH-1:0] s1_x;
    logic [NG-1:0]    s1_g0;
    logic [NG-1:0]    s1_p0;
    logic             s1_bin;

    // Stage 2 valid; diff/bout are the stage-2 data registers.
    logic             s2_valid;

    // Stage-2 combinational network.
    logic [NG:0]      gb;      // gb[k] = borrow into group k, gb[NG] = bout
    logic             acc;
    logic             pall;
    logic [WIDTH-1:0] diff_c;
    logic             bout_c;

    logic             accept;
    logic             adv2;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            bla_group2 u_grp (
                .a (a[GROUP_W*gi +: GROUP_W]),
                .b (b[GROUP_W*gi +: GROUP_W]),
                .g (grp_c[gi].g),
                .p (grp_c[gi].p),
                .x (x_c[GROUP_W*gi +: GROUP_W])
            );
            assign g0_c[gi] = ~a[GROUP_W*gi] & b[GROUP_W*gi];
            assign p0_c[gi] = ~a[GROUP_W*gi] | b[GROUP_W*gi];
        end
    endgenerate

    // Pipeline control: stage 2 can take new data when empty or draining.
    assign adv2      = ~s2_valid | out_ready;
    assign in_ready  = rst_n & (~s1_valid | ~s2_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid & rst_n;

    // Stage 1: capture group terms on acceptance, empty when passed onward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_gp    <= grp_c;
            s1_x     <= x_c;
            s1_g0    <= g0_c;
            s1_p0    <= p0_c;
            s1_bin   <= bin;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // Flat lookahead: each group borrow is a sum of products of G/P terms
    // and bin, then each bit's difference is a^b xor its borrow-in.
    always_comb begin
        gb     = '0;
        acc    = 1'b0;
        pall   = 1'b1;
        diff_c = '0;
        bout_c = 1'b0;
        for (int k = 0; k <= NG; k++) begin
            acc  = 1'b0;
            pall = 1'b1;
            for (int j = NG - 1; j >= 0; j--) begin
                if (j < k) begin
                    acc  = acc | (pall & s1_gp[j].g);
                    pall = pall & s1_gp[j].p;
                end
            end
            gb[k] = acc | (pall & s1_bin);
        end
        for (int k = 0; k < NG; k++) begin
            diff_c[GROUP_W*k]     = s1_x[GROUP_W*k] ^ gb[k];
            diff_c[GROUP_W*k + 1] = s1_x[GROUP_W*k + 1]
                                  ^ (s1_g0[k] | (s1_p0[k] & gb[k]));
        end
        bout_c = gb[NG];
    end

    // Stage 2: register the result; hold it while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                diff <= diff_c;
                bout <= bout_c;
            end
        end
    end

endmodule

// File: tb/tb_borrow_lookahead_sub.sv
// Bench for borrow_lookahead_sub (WIDTH=16): directed latency, corner,
// stall and reset scenarios, then a long randomized handshake run scored
// against an integer-arithmetic reference.
module tb_borrow_lookahead_sub;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    borrow_lookahead_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         out_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {bout,diff} is the low W+1 bits of the signed integer a-b-bin.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
        logic signed [31:0] d;
        d = $signed({16'd0, x}) - $signed({16'd0, y}) - $signed({31'd0, c});
        return d[W:0];
    endfunction

    // ---------------- driver ----------------
    // One clock cycle: drive at the falling edge, observe 1 time unit later,
    // score the output side and record any acceptance before the rising edge.
    task automatic step(input logic rst, input logic v, input logic [W-1:0] ai,
                        input logic [W-1:0] bi, input logic ci, input logic ordy);
        @(negedge clk);
        rst_n     = rst;
        in_valid  = v;
        a         = ai;
        b         = bi;
        bin       = ci;
        out_ready = ordy;
        #1;
        if (out_valid) begin
            out_cnt++;
            if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
            else                   check("result", {bout, diff}, exp_q[0]);
            if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    endtask

    task automatic idle(input logic ordy);
        step(1'b1, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1, ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0) idle(1'b1);
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [W-1:0] ra, rb;
    logic         rc;
    int           mode;
    int           cnt0;
    logic [4:0]   exp_rdy;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;

        // Reset state.
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_diff", diff, 16'h0000);
        check("rst_bout", bout, 1'b0);

        // 5 - 3: ready right after release, result exactly two cycles later.
        step(1'b1, 1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1);
        check("ready_after_release", in_ready, 1'b1);
        idle(1'b1);
        check("lat_t1_valid", out_valid, 1'b0);
        idle(1'b1);
        check("lat_t2_valid", out_valid, 1'b1);
        check("diff_5_3", {bout, diff}, 17'h00002);
        idle(1'b1);
        check("one_cycle_valid", out_valid, 1'b0);

        // Underflow corners, including bin=1 with a==b.
        step(1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1);
        idle(1'b1);
        check("diff_0_1", {bout, diff}, 17'h1FFFF);
        idle(1'b1);
        check("diff_eq_bin", {bout, diff}, 17'h1FFFF);
        drain();

        // Eight back-to-back operands: ready stays high, eight consecutive outputs.
        cnt0 = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            check("b2b_ready", in_ready, 1'b1);
            if (i >= 2) cnt0 += int'(out_valid);
        end
        idle(1'b1); cnt0 += int'(out_valid);
        idle(1'b1); cnt0 += int'(out_valid);
        check("b2b_out_cycles", cnt0, 8);
        idle(1'b1);
        check("b2b_after_valid", out_valid, 1'b0);
        drain();

        // Consumer stall for 5 cycles while streaming.
        exp_rdy = 5'b00011;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            check("stall_in_ready", in_ready, exp_rdy[i]);
            if (i >= 2) check("stall_out_valid", out_valid, 1'b1);
        end
        check("stall_held_count", exp_q.size(), 2);
        drain();

        // Reset with both stages full: everything in flight is discarded.
        step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        step(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        exp_q.delete();
        idle(1'b1);
        check("postrst_out_valid", out_valid, 1'b0);
        check("postrst_diff", diff, 16'h0000);
        check("postrst_bout", bout, 1'b0);
        check("postrst_in_ready", in_ready, 1'b1);
        cnt0 = out_cnt;
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("postrst_no_stale", out_cnt - cnt0, 0);

        // Random operands with random valid/ready.
        for (int i = 0; i < 10000; i++) begin
            mode = $urandom_range(0, 7);
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            case (mode)
                0: rb = ra;
                1: ra = 16'h0000;
                2: rb = 16'hFFFF;
                3: begin ra = 16'hFFFF; rb = 16'h0000; end
                default: ;
            endcase
            step(1'b1, ($urandom_range(0, 3) != 0), ra, rb, rc, ($urandom_range(0, 3) != 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
